// File: rtl/rs232_pkg.sv
// ---------------------------------------------------------------------------
// rs232_pkg
// Shared definitions for the RS232 word receiver: the deframer state
// encoding and the character/word geometry constants.
// ---------------------------------------------------------------------------
package rs232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_BITS      = 8;
    localparam int MID_SAMPLE     = 7;

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam int BIT_W = $clog2(DATA_BITS);

endpackage

// File: rtl/rs232_rx_tick.sv
// ---------------------------------------------------------------------------
// rs232_rx_tick
// Free-running oversample tick divider. The counter runs 0..DIV-1 and
// tick is high for exactly one clk cycle when the counter is at DIV-1.
//
// Ports:
//   clk   in  system clock, rising edge
//   reset in  asynchronous active-high reset (counter returns to 0)
//   tick  out one-cycle pulse every DIV clk cycles
// ---------------------------------------------------------------------------
module rs232_rx_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == CNT_W'(DIV - 1));
    assign tick = wrap;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rs232_word_receiver.sv
// ---------------------------------------------------------------------------
// rs232_word_receiver
// Receive side of the RS232 link. The serial line is synchronised, sampled
// at OVERSAMPLE ticks per bit and deframed (start, 8 data LSB first, stop).
// Four accepted bytes form one 32-bit word (byte0 in bits 7:0), which is
// presented on outData/outStatus until acknowledged via inStatus.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   rxd        in   serial line, idles high, asynchronous to clk
//   inStatus   in   ack; consumes the word on an edge where outStatus=1
//   outStatus  out  word valid, held until acked
//   outData    out  assembled 32-bit word
//   frameError out  one-cycle pulse on a bad stop bit
//   overrun    out  one-cycle pulse when a completed word is dropped
// ---------------------------------------------------------------------------
module rs232_word_receiver
    import rs232_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 9600,
    parameter int OVERSAMPLE   = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic        inStatus,
    output logic        outStatus,
    output logic [31:0] outData,
    output logic        frameError,
    output logic        overrun
);

    localparam int DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int SAMP_W   = $clog2(OVERSAMPLE);
    localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
    localparam int TO_W     = $clog2(TO_TICKS);
    localparam int STAGE_W  = DATA_BITS * (BYTES_PER_WORD - 1);

    logic tick;

    rs232_rx_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchroniser; both stages reset to the idle (high) level
    // so no false start bit is seen after reset.
    logic sync1_q;
    logic rx_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rx_s_q  <= sync1_q;
        end
    end

    rx_state_e            state_q,       state_d;
    logic [SAMP_W-1:0]    samp_q,        samp_d;
    logic [BIT_W-1:0]     bitcnt_q,      bitcnt_d;
    logic [DATA_BITS-1:0] shift_q,       shift_d;
    logic [IDX_W-1:0]     idx_q,         idx_d;
    logic [STAGE_W-1:0]   stage_q,       stage_d;
    logic [TO_W-1:0]      to_cnt_q,      to_cnt_d;
    logic                 out_status_q,  out_status_d;
    logic [31:0]          out_data_q,    out_data_d;
    logic                 frame_error_q, frame_error_d;
    logic                 overrun_q,     overrun_d;

    logic samp_last;
    assign samp_last = (samp_q == SAMP_W'(OVERSAMPLE - 1));

    always_comb begin
        state_d       = state_q;
        samp_d        = samp_q;
        bitcnt_d      = bitcnt_q;
        shift_d       = shift_q;
        idx_d         = idx_q;
        stage_d       = stage_q;
        to_cnt_d      = to_cnt_q;
        out_status_d  = out_status_q;
        out_data_d    = out_data_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;

        // Ack first; a word completing on the same edge overrides it below.
        if (out_status_q && inStatus) begin
            out_status_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        state_d  = ST_START;
                        samp_d   = '0;
                        to_cnt_d = '0;
                    end else if (idx_q != '0) begin
                        // Stale partial word: drop it after TIMEOUT_BITS bit-times.
                        if (to_cnt_q == TO_W'(TO_TICKS - 1)) begin
                            idx_d    = '0;
                            stage_d  = '0;
                            to_cnt_d = '0;
                        end else begin
                            to_cnt_d = to_cnt_q + TO_W'(1);
                        end
                    end
                end
            end

            ST_START: begin
                if (tick) begin
                    if (samp_q == SAMP_W'(MID_SAMPLE)) begin
                        samp_d = '0;
                        if (!rx_s_q) begin
                            state_d  = ST_DATA;
                            bitcnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;   // glitch, not a start bit
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (samp_last) begin
                        samp_d            = '0;
                        shift_d[bitcnt_q] = rx_s_q;
                        if (bitcnt_q == BIT_W'(DATA_BITS - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            bitcnt_d = bitcnt_q + BIT_W'(1);
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    if (samp_last) begin
                        samp_d = '0;
                        if (rx_s_q) begin
                            // Accept at mid stop bit; do not wait for its end.
                            state_d = ST_IDLE;
                            if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
                                idx_d   = '0;
                                stage_d = '0;
                                if (!out_status_q || inStatus) begin
                                    out_data_d   = {shift_q, stage_q};
                                    out_status_d = 1'b1;
                                end else begin
                                    overrun_d = 1'b1;
                                end
                            end else begin
                                stage_d[{idx_q, 3'b000} +: DATA_BITS] = shift_q;
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end else begin
                            frame_error_d = 1'b1;
                            idx_d         = '0;
                            stage_d       = '0;
                            state_d       = ST_BREAK;
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end

            ST_BREAK: begin
                // Line held low (break or bad framing): resync on the next high.
                if (tick && rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            samp_q        <= '0;
            bitcnt_q      <= '0;
            shift_q       <= '0;
            idx_q         <= '0;
            stage_q       <= '0;
            to_cnt_q      <= '0;
            out_status_q  <= 1'b0;
            out_data_q    <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_q        <= samp_d;
            bitcnt_q      <= bitcnt_d;
            shift_q       <= shift_d;
            idx_q         <= idx_d;
            stage_q       <= stage_d;
            to_cnt_q      <= to_cnt_d;
            out_status_q  <= out_status_d;
            out_data_q    <= out_data_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign outStatus  = out_status_q;
    assign outData    = out_data_q;
    assign frameError = frame_error_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_rs232_word_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_rs232_word_receiver
// Directed bench: DIV = 1600000/(10000*16) = 10, so one bit is 160 clk.
// ---------------------------------------------------------------------------
module tb_rs232_word_receiver;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int BIT_CLK  = 160;

    logic        clk = 1'b0;
    logic        reset;
    logic        rxd;
    logic        inStatus;
    logic        outStatus;
    logic [31:0] outData;
    logic        frameError;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    rs232_word_receiver #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .OVERSAMPLE   (16),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .inStatus   (inStatus),
        .outStatus  (outStatus),
        .outData    (outData),
        .frameError (frameError),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Count cycles each pulse output is high; a clean pulse adds exactly 1.
    always @(negedge clk) begin
        if (frameError) fe_cnt++;
        if (overrun)    ov_cnt++;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic ack_word(input string tag);
        @(negedge clk);
        inStatus = 1'b1;
        @(negedge clk);
        inStatus = 1'b0;
        check_value(tag, {31'b0, outStatus}, 32'd0);
    endtask

    int fe0, ov0, n;

    initial begin
        reset    = 1'b1;
        rxd      = 1'b1;
        inStatus = 1'b0;
        repeat (3) @(negedge clk);
        check_value("reset_outStatus",  {31'b0, outStatus},  32'd0);
        check_value("reset_outData",    outData,             32'd0);
        check_value("reset_frameError", {31'b0, frameError}, 32'd0);
        check_value("reset_overrun",    {31'b0, overrun},    32'd0);
        reset = 1'b0;
        repeat (BIT_CLK) @(negedge clk);

        // Word 0xDEADBEEF; valid within 100 clk of the 4th stop mid-bit.
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        check_value("w1_not_valid_after_3", {31'b0, outStatus}, 32'd0);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(8'hDE >> i);
        rxd = 1'b1;
        n = 0;
        while (!outStatus && n < 180) begin
            @(negedge clk);
            n++;
        end
        check_value("w1_valid", {31'b0, outStatus}, 32'd1);
        check_value("w1_data", outData, 32'hDEADBEEF);
        repeat (BIT_CLK) @(negedge clk);
        ack_word("w1_ack");

        // Short low glitch: no outputs change.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rxd = 1'b0;
        repeat (30) @(negedge clk);
        rxd = 1'b1;
        repeat (400) @(negedge clk);
        check_value("glitch_outStatus", {31'b0, outStatus}, 32'd0);
        check_value("glitch_outData", outData, 32'hDEADBEEF);
        check_value("glitch_fe", fe_cnt - fe0, 32'd0);
        check_value("glitch_ov", ov_cnt - ov0, 32'd0);

        // Bad stop bit, then a clean word.
        send_byte(8'h55, 1'b0);
        drive_bit(1'b1);
        check_value("fe_pulse", fe_cnt - fe0, 32'd1);
        check_value("fe_no_valid", {31'b0, outStatus}, 32'd0);
        send_word(32'h04030201);
        check_value("w2_valid", {31'b0, outStatus}, 32'd1);
        check_value("w2_data", outData, 32'h04030201);
        check_value("w2_ov", ov_cnt - ov0, 32'd0);
        check_value("w2_fe", fe_cnt - fe0, 32'd1);
        ack_word("w2_ack");

        // Overrun: second word dropped while the first is pending.
        ov0 = ov_cnt;
        send_word(32'h11111111);
        check_value("ovr_first_valid", {31'b0, outStatus}, 32'd1);
        check_value("ovr_first_data", outData, 32'h11111111);
        check_value("ovr_no_pulse_yet", ov_cnt - ov0, 32'd0);
        send_word(32'h22222222);
        check_value("ovr_pulse", ov_cnt - ov0, 32'd1);
        check_value("ovr_data_kept", outData, 32'h11111111);
        check_value("ovr_still_valid", {31'b0, outStatus}, 32'd1);
        ack_word("ovr_ack");

        // Partial word discarded after idle timeout.
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        repeat (25 * BIT_CLK) @(negedge clk);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        check_value("to_not_valid", {31'b0, outStatus}, 32'd0);
        send_byte(8'h44, 1'b1);
        check_value("to_valid", {31'b0, outStatus}, 32'd1);
        check_value("to_data", outData, 32'h44332211);

        // Reset mid-frame (bit 4) with a word pending: outputs clear at once.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(8'h5A >> i);
        rxd = 1'b0;
        repeat (80) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_value("rst_async_outStatus", {31'b0, outStatus}, 32'd0);
        check_value("rst_async_outData", outData, 32'd0);
        check_value("rst_async_flags", {30'b0, frameError, overrun}, 32'd0);
        repeat (5) @(negedge clk);
        rxd   = 1'b1;
        reset = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        send_word(32'hCAFEF00D);
        check_value("rst_after_valid", {31'b0, outStatus}, 32'd1);
        check_value("rst_after_data", outData, 32'hCAFEF00D);
        ack_word("rst_after_ack");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
